bfly_pipe: RTL and testbench

Parametrised, pipelined radix-2 decimation-in-time butterfly for the FFT datapath. Each transfer takes two complex samples A and B plus a twiddle W, and produces A + B·W and A − B·W. Arithmetic is rounded, optionally scaled and saturated, and results leave through a three-stage valid/ready pipeline. One instance serves each stage of the iterative FFT engine.

---
 rtl/fft_pkg.sv | 33 +++
 rtl/cplx_mult_pipe.sv | 69 ++++++
 rtl/bfly_pipe.sv | 103 ++++++++++
 tb/tb_bfly_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT datapath types, twiddle Q-format constants and rounding helper
package fft_pkg;

  localparam int DATA_W  = 16;
  localparam int TW_W    = 16;
  localparam int TW_FRAC = TW_W - 1;
  localparam int TW_ONE  = 1 << TW_FRAC;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  // Optional round-half-up halving, then clamp into a data_w-bit signed range.
  function automatic logic signed [31:0] sat_round(
    input  logic signed [31:0] x,
    input  logic               scale,
    input  int                 data_w,
    output logic               ovf
  );
    logic signed [31:0] v;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi  = (32'sd1 <<< (data_w - 1)) - 32'sd1;
    lo  = -(32'sd1 <<< (data_w - 1));
    v   = scale ? ((x + 32'sd1) >>> 1) : x;
    ovf = (v > hi) || (v < lo);
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    return v;
  endfunction

endpackage

// File: rtl/cplx_mult_pipe.sv
// rtl/cplx_mult_pipe.sv - two-stage registered complex multiply B*W with round-to-nearest
module cplx_mult_pipe
  import fft_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16,
  parameter int SIDE_W = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [TW_W-1:0]   tw_re,
  input  logic signed [TW_W-1:0]   tw_im,
  input  logic [SIDE_W-1:0]        side,
  output logic                     out_valid,
  output logic signed [DATA_W+1:0] t_re,
  output logic signed [DATA_W+1:0] t_im,
  output logic [SIDE_W-1:0]        side_q
);
  localparam int PW  = DATA_W + TW_W;
  localparam int SW  = PW + 1;
  localparam int TWD = DATA_W + 2;
  localparam logic signed [SW-1:0] RND = {{(SW-TW_W+1){1'b0}}, 1'b1, {(TW_W-2){1'b0}}};

  logic                 v1;
  logic signed [PW-1:0] pr_rr, pr_ii, pr_ri, pr_ir;
  logic [SIDE_W-1:0]    side1;
  logic signed [SW-1:0] sum_re, sum_im;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      pr_rr <= '0;
      pr_ii <= '0;
      pr_ri <= '0;
      pr_ir <= '0;
      side1 <= '0;
    end else if (en) begin
      v1    <= in_valid;
      pr_rr <= PW'(b_re) * PW'(tw_re);
      pr_ii <= PW'(b_im) * PW'(tw_im);
      pr_ri <= PW'(b_re) * PW'(tw_im);
      pr_ir <= PW'(b_im) * PW'(tw_re);
      side1 <= side;
    end
  end

  // One extra bit absorbs the W = -1.0 corner; the shifted result always fits DATA_W+2.
  assign sum_re = SW'(pr_rr) - SW'(pr_ii) + RND;
  assign sum_im = SW'(pr_ri) + SW'(pr_ir) + RND;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      t_re      <= '0;
      t_im      <= '0;
      side_q    <= '0;
    end else if (en) begin
      out_valid <= v1;
      t_re      <= TWD'(sum_re >>> (TW_W - 1));
      t_im      <= TWD'(sum_im >>> (TW_W - 1));
      side_q    <= side1;
    end
  end

endmodule

// File: rtl/bfly_pipe.sv
// rtl/bfly_pipe.sv - pipelined radix-2 DIT butterfly with rounding, optional halving and saturation
module bfly_pipe
  import fft_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16,
  parameter int SCALE  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [TW_W-1:0]   tw_re,
  input  logic signed [TW_W-1:0]   tw_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] y0_re,
  output logic signed [DATA_W-1:0] y0_im,
  output logic signed [DATA_W-1:0] y1_re,
  output logic signed [DATA_W-1:0] y1_im,
  output logic                     y_ovf,
  output logic                     ovf_sticky,
  input  logic                     ovf_clr
);
  localparam int T_W   = DATA_W + 2;
  localparam int SUM_W = DATA_W + 3;

  logic                     en, v2, v3;
  logic [2*DATA_W-1:0]      a2;
  logic signed [DATA_W-1:0] a2_re, a2_im;
  logic signed [T_W-1:0]    t_re, t_im;
  logic signed [SUM_W-1:0]  s [4];
  logic signed [DATA_W-1:0] yn [4];
  logic [3:0]               sat;

  // Single global stall: nothing moves while a result waits downstream.
  assign en        = !v3 || out_ready;
  assign in_ready  = en;
  assign out_valid = v3;
  assign a2_re     = a2[2*DATA_W-1:DATA_W];
  assign a2_im     = a2[DATA_W-1:0];

  cplx_mult_pipe #(
    .DATA_W(DATA_W),
    .TW_W  (TW_W),
    .SIDE_W(2*DATA_W)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (in_valid),
    .b_re     (b_re),
    .b_im     (b_im),
    .tw_re    (tw_re),
    .tw_im    (tw_im),
    .side     ({a_re, a_im}),
    .out_valid(v2),
    .t_re     (t_re),
    .t_im     (t_im),
    .side_q   (a2)
  );

  always_comb begin
    sat  = '0;
    s[0] = SUM_W'(a2_re) + SUM_W'(t_re);
    s[1] = SUM_W'(a2_im) + SUM_W'(t_im);
    s[2] = SUM_W'(a2_re) - SUM_W'(t_re);
    s[3] = SUM_W'(a2_im) - SUM_W'(t_im);
    for (int i = 0; i < 4; i++) begin
      yn[i] = DATA_W'(sat_round(32'(s[i]), SCALE != 0, DATA_W, sat[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v3    <= 1'b0;
      y0_re <= '0;
      y0_im <= '0;
      y1_re <= '0;
      y1_im <= '0;
      y_ovf <= 1'b0;
    end else if (en) begin
      v3    <= v2;
      y0_re <= yn[0];
      y0_im <= yn[1];
      y1_re <= yn[2];
      y1_im <= yn[3];
      y_ovf <= |sat;
    end
  end

  // Set has priority over clear so a saturating result is never lost.
  always_ff @(posedge clk) begin
    if (rst) ovf_sticky <= 1'b0;
    else if (v3 && out_ready && y_ovf) ovf_sticky <= 1'b1;
    else if (ovf_clr) ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_bfly_pipe.sv
// tb/tb_bfly_pipe.sv - scoreboard bench for bfly_pipe at both scaling settings
module tb_bfly_pipe;
  import fft_pkg::*;

  localparam int DW  = DATA_W;
  localparam int TWW = TW_W;

  typedef struct packed {
    logic [1:0]          ovf;
    logic [7:0][DW-1:0]  y;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, ovf_clr = 1'b0;
  cplx_t a, b;
  logic signed [TWW-1:0] tw_re = '0, tw_im = '0;
  logic in_ready0, in_ready1, out_valid0, out_valid1, y_ovf0, y_ovf1, sticky0, sticky1;
  logic signed [DW-1:0] y0r0, y0i0, y1r0, y1i0, y0r1, y0i1, y1r1, y1i1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bfly_pipe #(.DATA_W(DW), .TW_W(TWW), .SCALE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a_re(a.re), .a_im(a.im), .b_re(b.re), .b_im(b.im), .tw_re(tw_re), .tw_im(tw_im),
    .out_valid(out_valid0), .out_ready(out_ready),
    .y0_re(y0r0), .y0_im(y0i0), .y1_re(y1r0), .y1_im(y1i0),
    .y_ovf(y_ovf0), .ovf_sticky(sticky0), .ovf_clr(ovf_clr)
  );

  bfly_pipe #(.DATA_W(DW), .TW_W(TWW), .SCALE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a_re(a.re), .a_im(a.im), .b_re(b.re), .b_im(b.im), .tw_re(tw_re), .tw_im(tw_im),
    .out_valid(out_valid1), .out_ready(out_ready),
    .y0_re(y0r1), .y0_im(y0i1), .y1_re(y1r1), .y1_im(y1i1),
    .y_ovf(y_ovf1), .ovf_sticky(sticky1), .ovf_clr(ovf_clr)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Butterfly from its arithmetic definition: nearest-integer product, then halve and clamp.
  function automatic exp_t model(input longint ar, ai, br, bi, wr, wi);
    exp_t   e;
    longint tr, ti, v, hi, lo;
    longint c[4];
    hi = (64'sd1 <<< (DW - 1)) - 1;
    lo = -(64'sd1 <<< (DW - 1));
    tr = longint'($floor(real'(br * wr - bi * wi) / real'(TW_ONE) + 0.5));
    ti = longint'($floor(real'(br * wi + bi * wr) / real'(TW_ONE) + 0.5));
    c[0] = ar + tr; c[1] = ai + ti; c[2] = ar - tr; c[3] = ai - ti;
    e = '0;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 4; k++) begin
        v = (s == 1) ? longint'($floor(real'(c[k]) / 2.0 + 0.5)) : c[k];
        if (v > hi) begin v = hi; e.ovf[s] = 1'b1; end
        else if (v < lo) begin v = lo; e.ovf[s] = 1'b1; end
        e.y[s*4+k] = DW'(v);
      end
    end
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.ovf = {y_ovf1, y_ovf0};
    o.y   = {y1i1, y1r1, y0i1, y0r1, y1i0, y1r0, y0i0, y0r0};
    return o;
  endfunction

  task automatic cmp(input string tag, input exp_t e);
    exp_t o;
    o = observed();
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_scale%0d_comp%0d", tag, i / 4, i % 4),
          longint'($signed(o.y[i])), longint'($signed(e.y[i])));
    chk($sformatf("%s_ovf_scale0", tag), o.ovf[0], e.ovf[0]);
    chk($sformatf("%s_ovf_scale1", tag), o.ovf[1], e.ovf[1]);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid0) begin
      if (out_ready) begin
        chk("in_ready_open", in_ready0, 1);
        chk("valid_scale1", out_valid1, 1);
        if (q.size() == 0) chk("unexpected_output_queue_size", 0, 1);
        else cmp("out", q.pop_front());
      end else begin
        chk("in_ready_stall", in_ready0, 0);
        if (q.size() != 0) cmp("hold", q[0]);
      end
    end
  end

  function automatic cplx_t mk(input int re, input int im);
    cplx_t c;
    c.re = DW'(re);
    c.im = DW'(im);
    return c;
  endfunction

  function automatic logic signed [DW-1:0] rnd_d();
    int k;
    k = $urandom_range(0, 7);
    if (k == 0) return {1'b1, {(DW-1){1'b0}}};
    if (k == 1) return {1'b0, {(DW-1){1'b1}}};
    return DW'($urandom);
  endfunction

  function automatic logic signed [TWW-1:0] rnd_w();
    int k;
    k = $urandom_range(0, 7);
    if (k == 0) return {1'b1, {(TWW-1){1'b0}}};
    if (k == 1) return {1'b0, {(TWW-1){1'b1}}};
    return TWW'($urandom);
  endfunction

  task automatic send(input cplx_t sa, input cplx_t sb, input logic signed [TWW-1:0] wr, wi);
    int tries;
    tries = 0;
    a = sa; b = sb; tw_re = wr; tw_im = wi; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready0) begin
        q.push_back(model(longint'($signed(sa.re)), longint'($signed(sa.im)),
                          longint'($signed(sb.re)), longint'($signed(sb.im)),
                          longint'($signed(wr)), longint'($signed(wi))));
        last_acc = cyc;
        @(posedge clk); #1;
        break;
      end
      tries++;
      if (tries > 200) begin
        chk("send_timeout_in_ready", 0, 1);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_latency(input string name, input int acc);
    int n;
    n = 0;
    while (!out_valid0 && n < 20) begin @(negedge clk); n++; end
    chk(name, cyc - acc, 3);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin @(posedge clk); n++; end
    chk(name, q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    int stale;
    a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid0, 0);
    chk("reset_in_ready", in_ready0, 1);
    chk("reset_sticky", sticky0, 0);
    chk("reset_y0_re", y0r0, 0);
    chk("reset_y_ovf", y_ovf0, 0);
    @(posedge clk); #1;

    send(mk(1000, 0), mk(500, 0), 16'sd32767, 16'sd0);
    in_valid = 1'b0;
    expect_latency("t1_latency", last_acc);
    wait_drain("t1_drain");

    send(mk(0, 0), mk(500, 0), 16'sd0, -16'sd32768);
    in_valid = 1'b0;
    wait_drain("t2_drain");

    send(mk(32767, 0), mk(32767, 0), 16'sd32767, 16'sd0);
    in_valid = 1'b0;
    wait_drain("t3_drain");
    @(negedge clk);
    chk("t3_sticky_set", sticky0, 1);
    chk("t4_sticky_scaled_clear", sticky1, 0);
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    @(negedge clk);
    chk("t3_sticky_cleared", sticky0, 0);
    @(posedge clk); #1;

    send(mk(32767, 0), mk(32767, 0), 16'sd32767, 16'sd0);
    in_valid = 1'b0;
    wait_drain("t4_drain");
    @(negedge clk);
    chk("t4_sticky_scaled", sticky1, 0);
    @(posedge clk); #1;

    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 5; i++) send(mk(rnd_d(), rnd_d()), mk(rnd_d(), rnd_d()), rnd_w(), rnd_w());
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain("t5_drain");

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(mk(rnd_d(), rnd_d()), mk(rnd_d(), rnd_d()), rnd_w(), rnd_w());
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("random_drain");

    send(mk(rnd_d(), rnd_d()), mk(rnd_d(), rnd_d()), rnd_w(), rnd_w());
    send(mk(rnd_d(), rnd_d()), mk(rnd_d(), rnd_d()), rnd_w(), rnd_w());
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", out_valid0, 0);
    chk("t6_out_valid_scaled", out_valid1, 0);
    chk("t6_y0_re", y0r0, 0);
    chk("t6_y1_im", y1i0, 0);
    chk("t6_y_ovf", y_ovf0, 0);
    chk("t6_in_ready", in_ready0, 1);
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid0 || out_valid1) stale++;
    end
    chk("t6_stale_outputs", stale, 0);
    @(posedge clk); #1;
    send(mk(1234, -567), mk(-890, 321), 16'sd23170, -16'sd23170);
    in_valid = 1'b0;
    expect_latency("t6_latency", last_acc);
    wait_drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
